// File: rtl/pipe_if.sv
// Instruction-fetch stage: owns the PC, handshakes word reads with instruction memory and feeds the
// IF/ID register through a one-entry skid buffer. Define FETCH_PERF_CNT_EN to add fetch/stall counters.
module pipe_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] PCp1F,
    output logic        validF,
    output logic        flushD
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic {S_RUN, S_DRAIN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] redirect_pc;
    logic        redirect;
    logic        accept;
    logic        out_free;
    logic        skid_v;
    logic [31:0] skid_instr;
    logic [31:0] skid_pcp1;

    assign flushD      = branch_taken | jump;
    assign redirect    = flushD;
    assign redirect_pc = branch_taken ? branch_target : jump_target;
    assign pc_next     = pc + PC_STEP;

    // A read is only issued while nothing can be lost: running, skid free, out of reset.
    assign imem_req  = (state == S_RUN) && !skid_v && !RST;
    assign imem_addr = pc;
    assign accept    = imem_req && imem_ack;
    assign out_free  = !validF || !STALL;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_RUN;
            pc          <= RESET_PC;
            validF      <= 1'b0;
            instruction <= 32'h0;
            PCp1F       <= 32'h0;
            skid_v      <= 1'b0;
        end else if (redirect) begin
            pc          <= redirect_pc;
            validF      <= 1'b0;
            instruction <= 32'h0;
            skid_v      <= 1'b0;
            // An unanswered read must still be drained so its late data is not taken as the target.
            if (state == S_RUN)
                state <= (imem_req && !imem_ack) ? S_DRAIN : S_RUN;
            else
                state <= imem_ack ? S_RUN : S_DRAIN;
        end else begin
            if (state == S_DRAIN && imem_ack)
                state <= S_RUN;
            if (accept)
                pc <= pc_next;
            if (out_free) begin
                if (skid_v) begin
                    instruction <= skid_instr;
                    PCp1F       <= skid_pcp1;
                    validF      <= 1'b1;
                    skid_v      <= 1'b0;
                end else if (accept) begin
                    instruction <= imem_rdata;
                    PCp1F       <= pc_next;
                    validF      <= 1'b1;
                end else begin
                    instruction <= 32'h0;
                    validF      <= 1'b0;
                end
            end else if (accept) begin
                skid_v <= 1'b1;
            end
        end
    end

    // NOTE: skid payload needs no reset; skid_v guards every use of it.
    always_ff @(posedge CLK) begin
        if (!RST && !redirect && !out_free && accept) begin
            skid_instr <= imem_rdata;
            skid_pcp1  <= pc_next;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            if (accept && !redirect)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (STALL && validF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
